// File: rtl/cnn_pkg.sv
// Shared types and constants for the CNN accelerator input fetch path.
package cnn_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } fetch_state_t;

  localparam int unsigned PIX_PER_WORD = 4;
  localparam logic [3:0]  OBI_BE_FULL  = 4'hF;

endpackage

// File: rtl/cnn_word_unpacker.sv
// Holds one fetched 32-bit word and hands its bytes out little-endian, byte 0 first.
module cnn_word_unpacker
  import cnn_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  i_load,
  input  logic [31:0]           i_word,
  input  logic                  i_pop,
  output logic [DATA_WIDTH-1:0] o_pixel,
  output logic                  o_last
);

  logic [31:0] r_word;
  logic [1:0]  r_byte_idx;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_word     <= '0;
      r_byte_idx <= '0;
    end else if (i_load) begin
      r_word     <= i_word;
      r_byte_idx <= '0;
    end else if (i_pop) begin
      r_byte_idx <= r_byte_idx + 2'd1;
    end
  end

  assign o_pixel = r_word[{r_byte_idx, 3'b000} +: DATA_WIDTH];
  assign o_last  = (r_byte_idx == 2'(PIX_PER_WORD - 1));

endmodule

// File: rtl/cnn_pixel_fetch.sv
// Reads an IMG_W x IMG_H 8-bit image over OBI and streams it out pixel by pixel.
// Define CNN_FETCH_PERF_EN to build the busy-but-no-handshake stall counter.
module cnn_pixel_fetch
  import cnn_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned IMG_W      = 28,
  parameter int unsigned IMG_H      = 28
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  obi_req_o,
  input  logic                  obi_gnt_i,
  output logic [ADDR_WIDTH-1:0] obi_addr_o,
  output logic                  obi_we_o,
  output logic [3:0]            obi_be_o,
  output logic [31:0]           obi_wdata_o,
  input  logic                  obi_rvalid_i,
  input  logic [31:0]           obi_rdata_i,
  output logic [DATA_WIDTH-1:0] pixel_o,
  output logic                  pixel_valid_o,
  input  logic                  pixel_ready_i,
  output logic [31:0]           stall_cnt_o
);

  localparam int unsigned NPIX = IMG_W * IMG_H;
  localparam int unsigned PCW  = $clog2(NPIX + 1);

  fetch_state_t          r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [PCW-1:0]        r_pix_left;
  logic                  w_start, w_hs, w_load, w_last_byte;

  assign w_start = (r_state == S_IDLE) && start_i;
  assign w_hs    = (r_state == S_DRAIN) && pixel_ready_i;
  assign w_load  = (r_state == S_WAIT) && obi_rvalid_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_pix_left <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start) begin
        r_addr     <= base_addr_i & ~ADDR_WIDTH'(3);
        r_pix_left <= PCW'(NPIX);
      end else begin
        if ((r_state == S_REQ) && obi_gnt_i) r_addr <= r_addr + ADDR_WIDTH'(4);
        if (w_hs) r_pix_left <= r_pix_left - PCW'(1);
      end
    end
  end

  // Pixel count reaching zero wins over the word boundary, so a partial last word ends the frame.
  always_comb begin
    w_state_nxt   = r_state;
    busy_o        = 1'b1;
    done_o        = 1'b0;
    obi_req_o     = 1'b0;
    pixel_valid_o = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy_o = 1'b0;
        if (start_i) w_state_nxt = S_REQ;
      end
      S_REQ: begin
        obi_req_o = 1'b1;
        if (obi_gnt_i) w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (obi_rvalid_i) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        pixel_valid_o = 1'b1;
        if (pixel_ready_i) begin
          if (r_pix_left == PCW'(1)) w_state_nxt = S_DONE;
          else if (w_last_byte)      w_state_nxt = S_REQ;
        end
      end
      S_DONE: begin
        done_o      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        busy_o      = 1'b0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign obi_addr_o  = r_addr;
  assign obi_we_o    = 1'b0;
  assign obi_be_o    = OBI_BE_FULL;
  assign obi_wdata_o = '0;

  cnn_word_unpacker #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_unpack (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .i_load (w_load),
    .i_word (obi_rdata_i),
    .i_pop  (w_hs),
    .o_pixel(pixel_o),
    .o_last (w_last_byte)
  );

`ifdef CNN_FETCH_PERF_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_stall_cnt <= '0;
    end else if (w_start) begin
      r_stall_cnt <= '0;
    end else if (busy_o && !w_hs && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt_o = r_stall_cnt;
`else
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_cnn_pixel_fetch.sv
// Directed bench for cnn_pixel_fetch: full 28x28 frames plus a 5x3 partial-word instance.
module tb_cnn_pixel_fetch;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        start, busy, done, req, gnt, we, rvalid, valid, ready;
  logic [31:0] base, addr, wdata, rdata, stall_cnt;
  logic [3:0]  be;
  logic [7:0]  pixel;

  logic        start2, busy2, done2, req2, gnt2, we2, rvalid2, valid2, ready2;
  logic [31:0] base2, addr2, wdata2, rdata2, stall_cnt2;
  logic [3:0]  be2;
  logic [7:0]  pixel2;

  cnn_pixel_fetch #(.DATA_WIDTH(8), .ADDR_WIDTH(32), .IMG_W(28), .IMG_H(28)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .base_addr_i(base),
    .busy_o(busy), .done_o(done), .obi_req_o(req), .obi_gnt_i(gnt),
    .obi_addr_o(addr), .obi_we_o(we), .obi_be_o(be), .obi_wdata_o(wdata),
    .obi_rvalid_i(rvalid), .obi_rdata_i(rdata), .pixel_o(pixel),
    .pixel_valid_o(valid), .pixel_ready_i(ready), .stall_cnt_o(stall_cnt)
  );

  cnn_pixel_fetch #(.DATA_WIDTH(8), .ADDR_WIDTH(32), .IMG_W(5), .IMG_H(3)) dut_small (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start2), .base_addr_i(base2),
    .busy_o(busy2), .done_o(done2), .obi_req_o(req2), .obi_gnt_i(gnt2),
    .obi_addr_o(addr2), .obi_we_o(we2), .obi_be_o(be2), .obi_wdata_o(wdata2),
    .obi_rvalid_i(rvalid2), .obi_rdata_i(rdata2), .pixel_o(pixel2),
    .pixel_valid_o(valid2), .pixel_ready_i(ready2), .stall_cnt_o(stall_cnt2)
  );

  int unsigned total = 0;
  int unsigned bad   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
    end
  endtask

  // Byte k of the word at address A is (A+k) mod 256, so pixel n of a 256-aligned frame is n mod 256.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [7:0] b;
    b = a[7:0];
    return {b + 8'd3, b + 8'd2, b + 8'd1, b};
  endfunction

  logic        clr = 1'b1;
  logic [31:0] exp_base = '0;
  bit          rand_en = 1'b0;
  int unsigned npix, pix_err, nreads, addr_err, ndone, stall_obs, hold_err;
  logic [7:0]  exp_pix, held_pix;
  logic        held_v, hs_q = 1'b0;
  logic [31:0] exp_addr, last_addr, gaddr_q;
  int unsigned outst_err = 0, stab_err = 0;

  always @(posedge clk) begin
    hs_q <= req && gnt;
    if (req && gnt) gaddr_q <= addr;
    if (clr) begin
      npix <= 0; pix_err <= 0; nreads <= 0; addr_err <= 0; ndone <= 0;
      stall_obs <= 0; hold_err <= 0; exp_pix <= '0; held_v <= 1'b0;
      exp_addr <= exp_base; last_addr <= '0;
    end else begin
      if (req && gnt) begin
        nreads    <= nreads + 1;
        last_addr <= addr;
        exp_addr  <= addr + 32'd4;
        if (addr !== exp_addr) addr_err <= addr_err + 1;
      end
      if (valid && ready) begin
        npix    <= npix + 1;
        exp_pix <= exp_pix + 8'd1;
        if (pixel !== exp_pix) pix_err <= pix_err + 1;
      end
      if (busy && !(valid && ready)) stall_obs <= stall_obs + 1;
      if (done) ndone <= ndone + 1;
      if (held_v && (!valid || pixel !== held_pix)) hold_err <= hold_err + 1;
      held_v   <= valid && !ready;
      held_pix <= pixel;
    end
  end

  // OBI subordinate: grant after 0..gmax cycles, rvalid 1..rmax cycles after grant.
  initial begin
    int unsigned gcnt, rcnt;
    bit outst, armed, pend;
    logic [31:0] paddr;
    gnt = 1'b0; rvalid = 1'b0; rdata = '0;
    gcnt = 0; rcnt = 0; outst = 1'b0; armed = 1'b0; pend = 1'b0; paddr = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        gnt = 1'b0; rvalid = 1'b0; outst = 1'b0; armed = 1'b0; pend = 1'b0;
      end else begin
        if (req && pend && !hs_q && addr !== paddr) stab_err++;
        pend  = req;
        paddr = addr;
        if (req && outst) outst_err++;
        if (rvalid) begin rvalid = 1'b0; outst = 1'b0; end
        if (hs_q) begin
          gnt = 1'b0; outst = 1'b1; armed = 1'b0;
          rcnt = rand_en ? $urandom_range(5, 1) : 1;
        end
        if (outst) begin
          if (rcnt <= 1) begin rvalid = 1'b1; rdata = mem_word(gaddr_q); end
          else rcnt--;
        end
        if (req && !outst) begin
          if (!armed) begin armed = 1'b1; gcnt = rand_en ? $urandom_range(5, 0) : 0; end
          if (gcnt == 0) gnt = 1'b1;
          else begin gcnt--; gnt = 1'b0; end
        end else begin
          gnt = 1'b0;
        end
      end
    end
  end

  logic        hs2_q = 1'b0;
  logic [31:0] gaddr2_q = '0;
  int unsigned nreads2 = 0;

  always @(posedge clk) begin
    hs2_q <= req2 && gnt2;
    if (req2 && gnt2) begin
      gaddr2_q <= addr2;
      nreads2  <= nreads2 + 1;
    end
  end

  initial begin
    gnt2 = 1'b1; rvalid2 = 1'b0; rdata2 = '0;
    forever begin
      @(negedge clk);
      rvalid2 = hs2_q;
      rdata2  = mem_word(gaddr2_q);
    end
  end

  // mode 0: zero-latency memory; 1: random gnt/rvalid delays plus a stray start; 2: ready 1,0,0 pattern.
  task automatic run_frame(input logic [31:0] b, input int mode, input int unsigned abort_at);
    int unsigned cyc;
    logic [31:0] eb;
    eb = b & 32'hFFFF_FFFC;
    rand_en = (mode == 1);
    ready   = 1'b1;
    @(negedge clk);
    exp_base = eb; clr = 1'b1; start = 1'b1; base = b;
    @(negedge clk);
    clr = 1'b0; start = 1'b0; base = 32'hDEAD_BEE0;
    check("req_after_start", {30'd0, busy, req}, 32'd3);
    check("first_addr", addr, eb);
    cyc = 1;
    while (!done && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      ready = (mode != 2) || (cyc % 3 == 0);
      start = (mode == 1) && (cyc == 300);
      if (cyc == 300) base = 32'h0000_8000;
      if (abort_at != 0 && npix == abort_at && valid) begin
        rst_n = 1'b0;
        #1;
        check("rst_req", req, 0);
        check("rst_addr", addr, 0);
        check("rst_valid", valid, 0);
        check("rst_pixel", pixel, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_stall", stall_cnt, 0);
        @(negedge clk);
        check("rst_hold_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
    end
    start = 1'b0;
    check("done_seen", done, 1);
    if (mode == 0) check("frame_cycles", cyc, 1177);
    @(negedge clk);
    check("busy_after_done", busy, 0);
    check("done_one_cycle", done, 0);
    @(negedge clk);
    check("npix", npix, 784);
    check("pix_order", pix_err, 0);
    check("nreads", nreads, 196);
    check("addr_seq", addr_err, 0);
    check("last_addr", last_addr, eb + 32'h30C);
    check("ndone", ndone, 1);
    check("hold_stable", hold_err, 0);
    check("addr_stable", stab_err, 0);
    check("one_outstanding", outst_err, 0);
`ifdef CNN_FETCH_PERF_EN
    check("stall_cnt", stall_cnt, stall_obs);
`else
    check("stall_cnt", stall_cnt, 0);
`endif
  endtask

  task automatic run_small();
    int unsigned n, cyc, perr, early;
    n = 0; cyc = 0; perr = 0; early = 0;
    @(negedge clk);
    start2 = 1'b1; base2 = 32'h0000_0002;
    @(negedge clk);
    start2 = 1'b0; base2 = '0;
    while (n < 15 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (done2) early++;
      if (valid2) begin
        if (pixel2 !== 8'(n)) perr++;
        n++;
        if (n == 15) begin
          @(negedge clk);
          check("small_done_after_last", done2, 1);
          @(negedge clk);
          check("small_idle", busy2, 0);
        end
      end
    end
    check("small_npix", n, 15);
    check("small_pix_order", perr, 0);
    check("small_no_early_done", early, 0);
    check("small_nreads", nreads2, 4);
    check("small_valid_low", valid2, 0);
  endtask

  initial begin
    start = 1'b0; base = '0; ready = 1'b1;
    start2 = 1'b0; base2 = '0; ready2 = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("reset_req", req, 0);
    check("reset_addr", addr, 0);
    check("reset_valid", valid, 0);
    check("reset_pixel", pixel, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_stall", stall_cnt, 0);
    check("const_we", we, 0);
    check("const_be", be, 32'hF);
    check("const_wdata", wdata, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    clr = 1'b0;
    run_small();
    run_frame(32'h0000_1000, 0, 0);
    run_frame(32'h0000_1000, 1, 0);
    run_frame(32'h0000_1000, 2, 0);
    run_frame(32'h0000_1000, 0, 300);
    run_frame(32'h0000_2003, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cnn_pixel_fetch.md
# cnn_pixel_fetch

Input-side stream stage of the CNN accelerator. On a start pulse it reads a full IMG_W×IMG_H 8-bit image from system memory through an OBI manager port, starting at a programmable word-aligned base address. It unpacks each 32-bit word into four pixels, little-endian with byte 0 first, and streams them in raster order with valid/ready into the 3×3 line buffer. It replaces the unconnected pixel source in front of the line buffer and reports completion to the control FSM.

## Interface
Parameters:
- DATA_WIDTH, 8, pixel width; must equal 8 (4 pixels per 32-bit word)
- ADDR_WIDTH, 32, OBI address width
- IMG_W, 28, image width in pixels
- IMG_H, 28, image height in pixels

Ports (reset rst_ni, asynchronous, active-low; clock clk_i):
- clk_i  in  1  clock
- rst_ni  in  1  async active-low reset
- start_i  in  1  single-cycle start; sampled only in IDLE
- base_addr_i  in  ADDR_WIDTH  image base; bits [1:0] ignored (treated as 0); sampled at start
- busy_o  out  1  high from the cycle after an accepted start until DONE is exited
- done_o  out  1  one-cycle pulse after the last pixel handshake
- obi_req_o  out  1  OBI request
- obi_gnt_i  in  1  OBI grant
- obi_addr_o  out  ADDR_WIDTH  word address
- obi_we_o  out  1  constant 0
- obi_be_o  out  4  constant 4'hF
- obi_wdata_o  out  32  constant 0
- obi_rvalid_i  in  1  response valid
- obi_rdata_i  in  32  response data
- pixel_o  out  DATA_WIDTH  pixel
- pixel_valid_o  out  1  pixel valid
- pixel_ready_i  in  1  downstream ready; tie 1 if the consumer cannot stall
- stall_cnt_o  out  32  stall counter (see Configuration)

## Operation
- FSM states: IDLE, REQ, WAIT, DRAIN, DONE.
- IDLE: when start_i=1, latch base_addr_i into addr_q and set pix_left=IMG_W*IMG_H. Go to REQ.
- REQ: obi_req_o=1 with obi_addr_o=addr_q. Address is held stable until obi_gnt_i. On grant, go to WAIT and add 4 to addr_q.
- WAIT: on obi_rvalid_i, register obi_rdata_i into word_q and clear byte_idx. Go to DRAIN.
- DRAIN: pixel_valid_o=1 and pixel_o=word_q[8*byte_idx +: 8]. On each handshake (valid&&ready), increment byte_idx and decrement pix_left.
  - After a handshake that leaves pix_left=0, go to DONE. This covers a partial last word when IMG_W*IMG_H is not a multiple of 4; the unused bytes are discarded.
  - Otherwise, after the byte_idx=3 handshake, go to REQ.
- DONE: done_o=1 for one cycle, then go to IDLE.
- At most one OBI transaction is outstanding. No request is issued while word_q still holds undelivered pixels.
- start_i is ignored outside IDLE.
- obi_rvalid_i outside WAIT is ignored. This is a protocol error by the subordinate.
- pixel_valid_o is never dropped before its handshake, and pixel_o is stable while pixel_valid_o=1 and pixel_ready_i=0.
- Address wrap: addr_q wraps modulo 2^ADDR_WIDTH with no error.

## Timing
- Reset values:
  - outputs: obi_req_o=0, obi_addr_o=0, pixel_valid_o=0, pixel_o=0, busy_o=0, done_o=0, stall_cnt_o=0
  - state=IDLE
  - internal registers all 0
- Start at cycle t: REQ with obi_req_o=1 at t+1.
- Grant at cycle g: WAIT from g+1.
- rvalid at cycle r: first pixel_valid_o at r+1.
- Full-throughput word period = 4 DRAIN cycles + REQ + WAIT + memory latency. With grant in the same cycle and rvalid one cycle later, that is 6 cycles per word.
- The last pixel handshake at cycle p gives done_o=1 at p+1 and IDLE (busy_o=0) at p+2. The earliest restart is start_i at p+2.
- An asserted rst_ni mid-frame aborts immediately to the reset state. No drain and no done pulse. The OBI subordinate shares the reset.

## Configuration
- CNN_FETCH_PERF_EN defined:
  - stall_cnt_o counts cycles with busy_o=1 and no pixel handshake.
  - It is cleared on an accepted start and saturates at 32'hFFFF_FFFF.
  - It holds its value after done.
- CNN_FETCH_PERF_EN undefined: stall_cnt_o is tied to 0 and no counter flops are built. The port list is identical in both cases.

## Structure
- cnn_pkg holds:
  - fetch_state_t, a 3-bit enum of the five states
  - PIX_PER_WORD=4
  - OBI_BE_FULL=4'hF
- Pixel count width is $clog2(IMG_W*IMG_H+1), a localparam inside the module.
- Sub-module cnn_word_unpacker: holds word_q and byte_idx; load/pop interface; outputs the current pixel and a last-byte flag. The FSM, address counter and pixel counter stay in cnn_pixel_fetch.

## Test plan
- Zero-latency memory: memory word i = {4i+3,4i+2,4i+1,4i} (mod 256), base=0x1000, ready always 1. Required: 784 pixels in order 0,1,2,…; 196 reads at 0x1000..0x130C; one done_o; 6 cycles per word.
- Random gnt delay (0–5) and rvalid delay (1–5): addr_o stable while req=1 and gnt=0; pixel stream unchanged; only one transaction outstanding.
- Downstream backpressure with pixel_ready_i toggling 1,0,0,1…: pixel_o held while stalled; no pixel lost or duplicated; with PERF_EN, stall_cnt_o equals the observed stall cycles.
- IMG_W=5, IMG_H=3 (15 pixels): 4 reads; last word delivers only 3 pixels; done_o one cycle after pixel 15.
- Reset asserted mid-DRAIN at pixel 300, then restart with base=0x2003: all outputs zero during reset; after restart the first read is at 0x2000 and the full frame is delivered.
- start_i pulsed while busy: ignored; frame count and the addresses read are unchanged.
